// File: rtl/sale_sequencer_if.sv
// ----------------------------------------------------------------------------
// sale_sequencer_if
// Handshake between the sale sequencer and the item-price table.
//   lookup_req     : sequencer -> table, lookup in progress
//   lookup_barcode : sequencer -> table, 4 BCD digits, stable while lookup_req
//   lookup_ack     : table -> sequencer, response valid (one cycle)
//   lookup_hit     : table -> sequencer, item found (qualified by lookup_ack)
//   lookup_price   : table -> sequencer, unit price (qualified by ack & hit)
// ----------------------------------------------------------------------------
interface sale_sequencer_if;
    logic        lookup_req;
    logic [15:0] lookup_barcode;
    logic        lookup_ack;
    logic        lookup_hit;
    logic [15:0] lookup_price;

    modport master (
        output lookup_req, lookup_barcode,
        input  lookup_ack, lookup_hit, lookup_price
    );

    modport slave (
        input  lookup_req, lookup_barcode,
        output lookup_ack, lookup_hit, lookup_price
    );
endinterface

// File: rtl/sale_sequencer.sv
// ----------------------------------------------------------------------------
// sale_sequencer
// Point-of-sale front end: four push buttons enter a 4-digit BCD barcode and a
// quantity, the barcode is looked up in an external price table, and the
// price*qty is added to a saturating running total.
//
// Ports
//   CLOCK_50 : system clock, single domain
//   RESET_N  : asynchronous active-low reset
//   KEY[3:0] : push buttons, active-low, asynchronous
//   SW[2:0]  : SW[0] = 0 digit layer, 1 command layer; SW[2:1] unused
//   lkp      : price-table handshake (sale_sequencer_if.master)
//   barcode  : digits entered so far, newest digit in [3:0]
//   qty      : selected quantity 1..4
//   total    : running sale total, saturates at 20'hFFFFF
//   state    : ENTRY=0 QTY=1 LOOKUP=2 ACCUM=3 ERROR=4
//   err      : high while in ERROR
// ----------------------------------------------------------------------------

// Per-key front end: 2-flop synchronizer, debouncer, press detector.
// The accepted level flips only after DEBOUNCE_CYCLES consecutive synchronized
// samples that disagree with it; a flip to 0 emits a one-cycle press pulse.
module sale_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] != r_level) begin
                // This sample is the DEBOUNCE_CYCLES-th disagreeing one in a row
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync[1];
                    r_cnt   <= '0;
                    r_press <= ~r_sync[1];
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;
endmodule

module sale_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 255
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [3:0]              KEY,
    input  logic [2:0]              SW,
    sale_sequencer_if.master        lkp,
    output logic [15:0]             barcode,
    output logic [2:0]              qty,
    output logic [19:0]             total,
    output logic [2:0]              state,
    output logic                    err
);
    typedef enum logic [2:0] {
        S_ENTRY  = 3'd0,
        S_QTY    = 3'd1,
        S_LOOKUP = 3'd2,
        S_ACCUM  = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    // ---------------- key front end ----------------
    logic [3:0] w_press;

    for (genvar g = 0; g < 4; g++) begin : g_key
        sale_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (CLOCK_50),
            .rst_n   (RESET_N),
            .i_key_n (KEY[g]),
            .o_press (w_press[g])
        );
    end

    // The layer switch is asynchronous as well; it settles long before a
    // debounced press can appear, so two flops are enough.
    logic [1:0] r_sw_sync;
    logic       w_layer;
    logic       w_sw_unused;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_sw_sync <= 2'b00;
        else          r_sw_sync <= {r_sw_sync[0], SW[0]};
    end

    assign w_layer     = r_sw_sync[1];
    assign w_sw_unused = ^SW[2:1];

    // Decode: only the highest-index pressed key counts in a given cycle,
    // even when that key has no meaning in the current layer.
    logic       w_digit_vld;
    logic [3:0] w_digit;
    logic       w_sel;
    logic       w_clr;

    always_comb begin
        w_digit_vld = 1'b0;
        w_digit     = 4'd0;
        w_sel       = 1'b0;
        w_clr       = 1'b0;
        if (!w_layer) begin
            w_digit_vld = |w_press;
            if      (w_press[3]) w_digit = 4'd1;
            else if (w_press[2]) w_digit = 4'd2;
            else if (w_press[1]) w_digit = 4'd3;
            else if (w_press[0]) w_digit = 4'd4;
        end else begin
            if      (w_press[3])                    w_sel = 1'b1;
            else if (w_press[0] && !(|w_press[2:1])) w_clr = 1'b1;
        end
    end

    // ---------------- sequencer ----------------
    state_t        r_state,   w_state_nxt;
    logic [15:0]   r_barcode, w_barcode_nxt;
    logic [2:0]    r_ndig,    w_ndig_nxt;
    logic [2:0]    r_qty,     w_qty_nxt;
    logic [19:0]   r_total,   w_total_nxt;
    logic [15:0]   r_price,   w_price_nxt;
    logic          r_req,     w_req_nxt;
    logic [15:0]   r_lbar,    w_lbar_nxt;
    logic [TW-1:0] r_tmo,     w_tmo_nxt;

    logic [18:0]   w_prod;
    logic [20:0]   w_sum;

    assign w_prod = 19'(r_price) * 19'(r_qty);
    assign w_sum  = {1'b0, r_total} + {2'b00, w_prod};

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_ENTRY;
            r_barcode <= 16'h0000;
            r_ndig    <= 3'd0;
            r_qty     <= 3'd1;
            r_total   <= 20'h00000;
            r_price   <= 16'h0000;
            r_req     <= 1'b0;
            r_lbar    <= 16'h0000;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_barcode <= w_barcode_nxt;
            r_ndig    <= w_ndig_nxt;
            r_qty     <= w_qty_nxt;
            r_total   <= w_total_nxt;
            r_price   <= w_price_nxt;
            r_req     <= w_req_nxt;
            r_lbar    <= w_lbar_nxt;
            r_tmo     <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_barcode_nxt = r_barcode;
        w_ndig_nxt    = r_ndig;
        w_qty_nxt     = r_qty;
        w_total_nxt   = r_total;
        w_price_nxt   = r_price;
        w_req_nxt     = r_req;
        w_lbar_nxt    = r_lbar;
        w_tmo_nxt     = r_tmo;

        case (r_state)
            S_ENTRY: begin
                if (w_clr) begin
                    w_barcode_nxt = 16'h0000;
                    w_ndig_nxt    = 3'd0;
                end else if (w_sel) begin
                    if (r_ndig == 3'd4) begin
                        w_state_nxt = S_QTY;
                        w_qty_nxt   = 3'd1;
                    end
                end else if (w_digit_vld) begin
                    w_barcode_nxt = {r_barcode[11:0], w_digit};
                    if (r_ndig != 3'd4) w_ndig_nxt = r_ndig + 3'd1;
                end
            end

            S_QTY: begin
                if (w_clr) begin
                    w_state_nxt   = S_ENTRY;
                    w_barcode_nxt = 16'h0000;
                    w_ndig_nxt    = 3'd0;
                end else if (w_sel) begin
                    w_state_nxt = S_LOOKUP;
                    w_req_nxt   = 1'b1;
                    w_lbar_nxt  = r_barcode;
                    w_tmo_nxt   = '0;
                end else if (w_digit_vld) begin
                    w_qty_nxt = w_digit[2:0];
                end
            end

            S_LOOKUP: begin
                // An ack in the final timeout cycle still wins over the timeout
                if (r_req && lkp.lookup_ack) begin
                    w_req_nxt = 1'b0;
                    if (lkp.lookup_hit) begin
                        w_price_nxt = lkp.lookup_price;
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end

            S_ACCUM: begin
                w_total_nxt   = w_sum[20] ? 20'hFFFFF : w_sum[19:0];
                w_state_nxt   = S_ENTRY;
                w_barcode_nxt = 16'h0000;
                w_ndig_nxt    = 3'd0;
            end

            S_ERROR: begin
                if (w_clr) begin
                    w_state_nxt   = S_ENTRY;
                    w_barcode_nxt = 16'h0000;
                    w_ndig_nxt    = 3'd0;
                end
            end

            default: begin
                w_state_nxt = S_ENTRY;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    assign lkp.lookup_req     = r_req;
    assign lkp.lookup_barcode = r_lbar;
    assign barcode            = r_barcode;
    assign qty                = r_qty;
    assign total              = r_total;
    assign state              = r_state;
    assign err                = (r_state == S_ERROR);
endmodule
